// File: rtl/axi_fifo_uart_top.sv
// Write-only AXI4-Lite slave that queues bytes in a synchronous FIFO and
// serializes them on an 8N1 UART line, LSB first.
module axi_fifo_uart_top #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic        tx
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [1:0]        REG_TXDATA  = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // AXI write channel latches and response
  logic             rdy_en_q;
  logic             aw_vld_q, aw_vld_d;
  logic [1:0]       aw_reg_q, aw_reg_d;
  logic             w_vld_q, w_vld_d;
  logic [7:0]       w_data_q, w_data_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             aw_hs, w_hs, commit, push;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full, fifo_empty, pop;

  // UART transmitter
  uart_state_e      state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_done;

  logic             unused_bits;
  assign unused_bits = ^{s_axi_wdata[31:8], s_axi_awaddr[1:0]};

  // rdy_en_q keeps both readys low through reset and its first release cycle.
  assign s_axi_awready = rdy_en_q & ~aw_vld_q & ~bvalid_q;
  assign s_axi_wready  = rdy_en_q & ~w_vld_q & ~bvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign commit = aw_vld_q & w_vld_q & ~bvalid_q;
  assign push   = commit & (aw_reg_q == REG_TXDATA) & ~fifo_full;

  always_comb begin
    aw_vld_d = aw_vld_q;
    aw_reg_d = aw_reg_q;
    w_vld_d  = w_vld_q;
    w_data_d = w_data_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (aw_hs) begin
      aw_vld_d = 1'b1;
      aw_reg_d = s_axi_awaddr[3:2];
    end
    if (w_hs) begin
      w_vld_d  = 1'b1;
      w_data_d = s_axi_wdata[7:0];
    end
    if (commit) begin
      aw_vld_d = 1'b0;
      w_vld_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = push ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en_q <= 1'b0;
      aw_vld_q <= 1'b0;
      aw_reg_q <= 2'd0;
      w_vld_q  <= 1'b0;
      w_data_q <= 8'd0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      rdy_en_q <= 1'b1;
      aw_vld_q <= aw_vld_d;
      aw_reg_q <= aw_reg_d;
      w_vld_q  <= w_vld_d;
      w_data_q <= w_data_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= w_data_q;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
    end
  end

  assign baud_done = (baud_q == BAUD_LAST);
  assign pop       = (state_q == ST_IDLE) & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          shift_d = mem_q[rptr_q];
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is derived from the next state so tx toggles with the state register.
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_axi_fifo_uart_top.sv
// Randomized bench for axi_fifo_uart_top: AXI writes against a byte-queue
// model, with a UART line decoder checking every transmitted frame.
module tb_axi_fifo_uart_top;

  localparam int C     = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        tx;

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];
  int          room;

  axi_fifo_uart_top #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .tx            (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[3'(idx - 1)];
  endfunction

  // Line decoder: samples mid-bit, drops frames interrupted by reset.
  initial begin : uart_mon
    logic       aborted;
    logic       start_ok;
    logic       stop_ok;
    logic [7:0] rx;
    int         st;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        st      = cyc;
        aborted = 1'b0;
        rx      = 8'd0;
        for (int i = 0; i < C / 2; i++) begin
          @(negedge clk);
          if (reset !== 1'b1) aborted = 1'b1;
        end
        start_ok = (tx === 1'b0);
        for (int b = 0; b < 8; b++) begin
          for (int i = 0; i < C; i++) begin
            @(negedge clk);
            if (reset !== 1'b1) aborted = 1'b1;
          end
          rx[3'(b)] = tx;
        end
        for (int i = 0; i < C; i++) begin
          @(negedge clk);
          if (reset !== 1'b1) aborted = 1'b1;
        end
        stop_ok = (tx === 1'b1);
        if (!aborted) begin
          start_q.push_back(st);
          chk_eq("rx_start_bit", 32'(start_ok), 1);
          chk_eq("rx_stop_bit", 32'(stop_ok), 1);
          chk_eq("rx_frame_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk_eq("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [7:0] data, input int aw_dly,
                           input int w_dly, input int b_dly, output logic [1:0] resp);
    int n;
    fork
      begin
        logic hs;
        int   k;
        hs = 1'b0;
        k  = 0;
        repeat (aw_dly) @(negedge clk);
        awaddr  = addr;
        awvalid = 1'b1;
        do begin
          hs = awready;
          @(posedge clk);
          #1;
          k++;
          if (!hs) @(negedge clk);
        end while (!hs && k < 50);
        awvalid = 1'b0;
        chk_eq("aw_handshake", 32'(hs), 1);
        @(negedge clk);
        chk_eq("awready_drop", 32'(awready), 0);
      end
      begin
        logic hs;
        int   k;
        hs = 1'b0;
        k  = 0;
        repeat (w_dly) @(negedge clk);
        wdata  = {$urandom_range(0, 32'hFF_FFFF), data};
        wvalid = 1'b1;
        do begin
          hs = wready;
          @(posedge clk);
          #1;
          k++;
          if (!hs) @(negedge clk);
        end while (!hs && k < 50);
        wvalid = 1'b0;
        chk_eq("w_handshake", 32'(hs), 1);
        @(negedge clk);
        chk_eq("wready_drop", 32'(wready), 0);
      end
    join
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk_eq("bvalid_seen", 32'(bvalid), 1);
    resp = bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk_eq("bvalid_hold", 32'(bvalid), 1);
      chk_eq("bresp_hold", 32'(bresp), 32'(resp));
      chk_eq("awready_hold", 32'(awready), 0);
      chk_eq("wready_hold", 32'(wready), 0);
    end
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    @(negedge clk);
    chk_eq("bvalid_clear", 32'(bvalid), 0);
    chk_eq("awready_back", 32'(awready), 1);
    chk_eq("wready_back", 32'(wready), 1);
  endtask

  // Model: TXDATA accepted while the queue has room; any other register errors.
  task automatic do_write(input logic [3:0] addr, input logic [7:0] data, input int aw_dly,
                          input int w_dly, input int b_dly);
    logic       ok;
    logic [1:0] resp;
    ok = (addr[3:2] == 2'd0) && (room > 0);
    if (ok) begin
      room--;
      exp_q.push_back(data);
    end
    axi_write(addr, data, aw_dly, w_dly, b_dly, resp);
    chk_eq($sformatf("bresp_addr%0h_data%02h", addr, data), 32'(resp), ok ? 0 : 2);
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk_eq("drain_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2 * C) @(negedge clk);
    chk_eq("tx_idle_after_drain", 32'(tx), 1);
    room = DEPTH + 1;
  endtask

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: cycle budget exhausted, observed %0d cycles, expected under 60000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         t0;
    int         a_start;
    int         good[10];
    int         lows;
    int         len;
    logic [1:0] rg;
    reset   = 1'b1;
    awaddr  = 4'h0;
    awvalid = 1'b0;
    wdata   = 32'h0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    room    = DEPTH + 1;
    a_start = 0;
    for (int i = 0; i < 10; i++) good[i] = 0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("reset_tx", 32'(tx), 1);
    chk_eq("reset_bvalid", 32'(bvalid), 0);
    chk_eq("reset_bresp", 32'(bresp), 0);
    chk_eq("reset_awready", 32'(awready), 0);
    chk_eq("reset_wready", 32'(wready), 0);
    #1 reset = 1'b1;
    #1 chk_eq("awready_before_first_edge", 32'(awready), 0);
    @(negedge clk);
    chk_eq("release_awready", 32'(awready), 1);
    chk_eq("release_wready", 32'(wready), 1);
    chk_eq("release_tx", 32'(tx), 1);

    // Single 0xA5 write with exact line waveform.
    t0 = cyc;
    fork
      do_write(4'h0, 8'hA5, 0, 0, 0);
      begin
        int k;
        k = 0;
        while (tx !== 1'b0 && k < 40) begin
          @(negedge clk);
          k++;
        end
        a_start = cyc;
        for (int i = 0; i < 10 * C; i++) begin
          if (i > 0) @(negedge clk);
          if (tx === frame_bit(8'hA5, i / C)) good[4'(i / C)]++;
        end
        @(negedge clk);
        chk_eq("a5_idle_after_stop", 32'(tx), 1);
      end
    join
    chk_eq("a5_start_latency", 32'((a_start - t0) >= 2 && (a_start - t0) <= 4), 1);
    for (int b = 0; b < 10; b++) chk_eq($sformatf("a5_bit%0d_cycles", b), 32'(good[b]), 32'(C));
    drain(4 * 11 * C);

    // Back-to-back frames: exactly one idle cycle between stop and start.
    start_q.delete();
    do_write(4'h0, 8'h24, 0, 0, 0);
    do_write(4'h0, 8'h81, 0, 0, 0);
    do_write(4'h0, 8'h09, 0, 0, 0);
    drain(5 * 11 * C);
    chk_eq("b2b_frame_count", 32'(start_q.size()), 3);
    if (start_q.size() >= 3) begin
      chk_eq("b2b_gap_1", 32'(start_q[1] - start_q[0]), 32'(10 * C + 1));
      chk_eq("b2b_gap_2", 32'(start_q[2] - start_q[1]), 32'(10 * C + 1));
    end

    // Split channels with a stalled response.
    do_write(4'h0, 8'h5A, 3, 0, 5);
    drain(3 * 11 * C);

    // Unmapped registers.
    do_write(4'h4, 8'h77, 0, 0, 0);
    do_write(4'hC, 8'h66, 1, 0, 2);
    drain(2 * 11 * C);

    // Overflow: one byte goes straight to the shifter, DEPTH more fit, the rest error.
    for (int i = 0; i < DEPTH + 2; i++) do_write({2'b00, 2'($urandom)}, 8'($urandom), 0, 0, 0);
    drain((DEPTH + 3) * 11 * C);

    // Random bursts with random channel skew and response stalls.
    for (int burst = 0; burst < 6; burst++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        rg = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        do_write({rg, 2'($urandom)}, 8'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      end
      drain((len + 2) * 11 * C);
    end

    // Reset during the data bits of the second of three queued frames.
    do_write(4'h0, 8'($urandom), 0, 0, 0);
    do_write(4'h0, 8'h00, 0, 0, 0);
    do_write(4'h0, 8'($urandom), 0, 0, 0);
    lows = 0;
    while (exp_q.size() > 2 && lows < 20 * C) begin
      @(negedge clk);
      lows++;
    end
    chk_eq("rst_first_frame_done", 32'(exp_q.size()), 2);
    repeat (3 * C) @(negedge clk);
    chk_eq("rst_pre_tx_low", 32'(tx), 0);
    #1 reset = 1'b0;
    exp_q.delete();
    #1;
    chk_eq("rst_tx_immediate", 32'(tx), 1);
    chk_eq("rst_awready", 32'(awready), 0);
    chk_eq("rst_wready", 32'(wready), 0);
    chk_eq("rst_bvalid", 32'(bvalid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lows  = 0;
    repeat (30 * C) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk_eq("rst_no_frames_after_release", 32'(lows), 0);
    room = DEPTH + 1;
    do_write(4'h0, 8'h3C, 0, 0, 0);
    drain(3 * 11 * C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
